// File: rtl/avalon_s_pipeline_bridge.sv
// rtl/avalon_s_pipeline_bridge.sv - registered Avalon bridge with one outstanding transaction and optional timeout
//
// Purpose: isolates a matrix device port from a downstream device.
// Every output is driven from a register, so no combinational path crosses
// the bridge in either direction.
//
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   host_avn_*              - device port facing the bus matrix
//                             (read/write/address/byte_enable/writedata in,
//                              readdata/waitrequest out)
//   device_avn_*            - host port facing the downstream device
//                             (read/write/address/byte_enable/writedata out,
//                              readdata/waitrequest in)
//   err_timeout             - one-cycle pulse when a transaction is aborted by timeout
module avalon_s_pipeline_bridge #(
  parameter int unsigned     DW      = 32,
  parameter int unsigned     AW      = 32,
  parameter int unsigned     TO      = 0,
  parameter logic [DW-1:0]   TO_DATA = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_avn_read,
  input  logic              host_avn_write,
  input  logic [AW-1:0]     host_avn_address,
  input  logic [DW/8-1:0]   host_avn_byte_enable,
  input  logic [DW-1:0]     host_avn_writedata,
  output logic [DW-1:0]     host_avn_readdata,
  output logic              host_avn_waitrequest,
  output logic              device_avn_read,
  output logic              device_avn_write,
  output logic [AW-1:0]     device_avn_address,
  output logic [DW/8-1:0]   device_avn_byte_enable,
  output logic [DW-1:0]     device_avn_writedata,
  input  logic [DW-1:0]     device_avn_readdata,
  input  logic              device_avn_waitrequest,
  output logic              err_timeout
);

  // Counter only needs to reach TO-1; keep it at least one bit wide.
  localparam int unsigned   CW      = (TO > 1) ? $clog2(TO) : 1;
  localparam logic [CW-1:0] TO_LAST = (TO == 0) ? '0 : CW'(TO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      count                  <= '0;
      host_avn_waitrequest   <= 1'b1;
      host_avn_readdata      <= '0;
      device_avn_read        <= 1'b0;
      device_avn_write       <= 1'b0;
      device_avn_address     <= '0;
      device_avn_byte_enable <= '0;
      device_avn_writedata   <= '0;
      err_timeout            <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          host_avn_waitrequest <= 1'b1;
          if (host_avn_read || host_avn_write) begin
            // Write has priority when both commands are presented.
            device_avn_write       <= host_avn_write;
            device_avn_read        <= host_avn_read & ~host_avn_write;
            device_avn_address     <= host_avn_address;
            device_avn_byte_enable <= host_avn_byte_enable;
            device_avn_writedata   <= host_avn_writedata;
            count                  <= '0;
            state                  <= REQ;
          end
        end
        REQ: begin
          count <= count + 1'b1;
          if (!device_avn_waitrequest) begin
            // device_avn_read doubles as the stored command type.
            if (device_avn_read) host_avn_readdata <= device_avn_readdata;
            device_avn_read      <= 1'b0;
            device_avn_write     <= 1'b0;
            host_avn_waitrequest <= 1'b0;
            state                <= RESP;
          end else if ((TO != 0) && (count == TO_LAST)) begin
            if (device_avn_read) host_avn_readdata <= TO_DATA;
            device_avn_read      <= 1'b0;
            device_avn_write     <= 1'b0;
            host_avn_waitrequest <= 1'b0;
            err_timeout          <= 1'b1;
            state                <= RESP;
          end
        end
        RESP: begin
          // Host request is deliberately not sampled here so a held
          // request is not issued twice.
          host_avn_waitrequest <= 1'b1;
          state                <= IDLE;
        end
        default: begin
          host_avn_waitrequest <= 1'b1;
          state                <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_s_pipeline_bridge.sv
// tb/tb_avalon_s_pipeline_bridge.sv - directed vector bench for avalon_s_pipeline_bridge
module tb_avalon_s_pipeline_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_avn_read, host_avn_write;
  logic [31:0] host_avn_address;
  logic [3:0]  host_avn_byte_enable;
  logic [31:0] host_avn_writedata;
  logic [31:0] host_avn_readdata;
  logic        host_avn_waitrequest;
  logic        device_avn_read, device_avn_write;
  logic [31:0] device_avn_address;
  logic [3:0]  device_avn_byte_enable;
  logic [31:0] device_avn_writedata;
  logic [31:0] device_avn_readdata;
  logic        device_avn_waitrequest;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  avalon_s_pipeline_bridge #(.DW(32), .AW(32), .TO(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .host_avn_read          (host_avn_read),
    .host_avn_write         (host_avn_write),
    .host_avn_address       (host_avn_address),
    .host_avn_byte_enable   (host_avn_byte_enable),
    .host_avn_writedata     (host_avn_writedata),
    .host_avn_readdata      (host_avn_readdata),
    .host_avn_waitrequest   (host_avn_waitrequest),
    .device_avn_read        (device_avn_read),
    .device_avn_write       (device_avn_write),
    .device_avn_address     (device_avn_address),
    .device_avn_byte_enable (device_avn_byte_enable),
    .device_avn_writedata   (device_avn_writedata),
    .device_avn_readdata    (device_avn_readdata),
    .device_avn_waitrequest (device_avn_waitrequest),
    .err_timeout            (err_timeout)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] dev_rdata;
    logic [31:0] exp_rdata;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_idle();
    host_avn_read        = 1'b0;
    host_avn_write       = 1'b0;
    host_avn_address     = '0;
    host_avn_byte_enable = '0;
    host_avn_writedata   = '0;
  endtask

  // Issue one transaction and follow it cycle by cycle through REQ and RESP.
  task automatic run_txn(input vec_t v);
    int n;
    @(negedge clk);
    host_avn_read          = v.rd;
    host_avn_write         = v.wr;
    host_avn_address       = v.addr;
    host_avn_byte_enable   = v.be;
    host_avn_writedata     = v.wdata;
    device_avn_waitrequest = 1'b1;
    check("idle_wait", host_avn_waitrequest, 1);
    @(negedge clk);
    n = 0;
    for (int k = 0; k <= v.stall; k++) begin
      device_avn_waitrequest = (k < v.stall);
      device_avn_readdata    = v.dev_rdata;
      check("req_rd",    device_avn_read, v.exp_rd);
      check("req_wr",    device_avn_write, v.exp_wr);
      check("req_addr",  device_avn_address, v.addr);
      check("req_be",    device_avn_byte_enable, v.be);
      check("req_wdata", device_avn_writedata, v.wdata);
      check("req_wait",  host_avn_waitrequest, 1);
      check("req_err",   err_timeout, 0);
      if (device_avn_read || device_avn_write) n++;
      @(negedge clk);
    end
    check("cmd_cycles", n, v.stall + 1);
    check("resp_rd",    device_avn_read, 0);
    check("resp_wr",    device_avn_write, 0);
    check("resp_wait",  host_avn_waitrequest, 0);
    check("resp_rdata", host_avn_readdata, v.exp_rdata);
    check("resp_err",   err_timeout, 0);
    host_idle();
    device_avn_waitrequest = 1'b1;
    @(negedge clk);
    check("post_wait",  host_avn_waitrequest, 1);
    check("post_rdata", host_avn_readdata, v.exp_rdata);
  endtask

  initial begin
    int n, errs;
    logic [9:0] comp_mask, rd_mask;

    //          rd    wr    addr          be       wdata         stall dev_rdata     exp_rdata     rd    wr
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0000_0000, 0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 4'h3, 32'hDEAD_BEEF, 4, 32'h1234_5678, 32'hA5A5_0001, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 4'hC, 32'h1111_2222, 1, 32'h0000_0099, 32'hA5A5_0001, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_03FC, 4'hF, 32'h0000_0000, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 1'b0};
    // Accept on the last REQ cycle before timeout must win over the timeout.
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0480, 4'hF, 32'h0000_0000, 7, 32'hCAFE_0007, 32'hCAFE_0007, 1'b1, 1'b0};

    rst = 1'b1;
    host_idle();
    device_avn_waitrequest = 1'b1;
    device_avn_readdata    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_wait",  host_avn_waitrequest, 1);
    check("rst_rdata", host_avn_readdata, 0);
    check("rst_rd",    device_avn_read, 0);
    check("rst_wr",    device_avn_write, 0);
    check("rst_addr",  device_avn_address, 0);
    check("rst_be",    device_avn_byte_enable, 0);
    check("rst_wdata", device_avn_writedata, 0);
    check("rst_err",   err_timeout, 0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Timeout: device never accepts.
    @(negedge clk);
    host_avn_read          = 1'b1;
    host_avn_address       = 32'h0000_0500;
    host_avn_byte_enable   = 4'hF;
    device_avn_waitrequest = 1'b1;
    @(negedge clk);
    n = 0;
    errs = 0;
    for (int k = 0; k < 20 && device_avn_read; k++) begin
      n++;
      if (err_timeout) errs++;
      @(negedge clk);
    end
    check("to_cycles", n, 8);
    check("to_early_err", errs, 0);
    check("to_err",   err_timeout, 1);
    check("to_wait",  host_avn_waitrequest, 0);
    check("to_rdata", host_avn_readdata, 32'hFFFF_FFFF);
    check("to_rd",    device_avn_read, 0);
    host_idle();
    @(negedge clk);
    check("to_err_clr", err_timeout, 0);
    check("to_wait_back", host_avn_waitrequest, 1);

    // Reset while the device is stalling in REQ.
    @(negedge clk);
    host_avn_read    = 1'b1;
    host_avn_address = 32'h0000_0600;
    @(negedge clk);
    check("rr_req_rd", device_avn_read, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    host_idle();
    check("rr_rd",    device_avn_read, 0);
    check("rr_wait",  host_avn_waitrequest, 1);
    check("rr_rdata", host_avn_readdata, 0);
    check("rr_addr",  device_avn_address, 0);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (!host_avn_waitrequest || device_avn_read) n++;
      @(negedge clk);
    end
    check("rr_no_completion", n, 0);
    run_txn(vecs[0]);

    // Back-to-back: read held continuously, zero-wait device.
    device_avn_waitrequest = 1'b0;
    comp_mask = '0;
    rd_mask   = '0;
    for (int c = 0; c < 10; c++) begin
      comp_mask[c] = ~host_avn_waitrequest;
      rd_mask[c]   = device_avn_read;
      if (c == 2 || c == 5 || c == 8)
        check("b2b_rdata", host_avn_readdata, 32'h0000_1000 + c - 1);
      device_avn_readdata = 32'h0000_1000 + c;
      if (c == 0) begin
        host_avn_read    = 1'b1;
        host_avn_address = 32'h0000_0700;
      end
      if (c == 8) host_idle();
      @(negedge clk);
    end
    check("b2b_completions", comp_mask, 10'b01_0010_0100);
    check("b2b_dev_reads",   rd_mask,   10'b00_1001_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
